// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a WIDTH-bit JK flip-flop bank between requesters A and B.
// Optional grant statistics ports stat_a/stat_b are enabled by defining JK_BANK_STATS_EN.
module jk_bank_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [1:0]       op_a,
   input  logic [WIDTH-1:0] mask_a,
   input  logic             req_b,
   input  logic [1:0]       op_b,
   input  logic [WIDTH-1:0] mask_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec,
   output logic [WIDTH-1:0] q
`ifdef JK_BANK_STATS_EN
   ,
   output logic [7:0]       stat_a,
   output logic [7:0]       stat_b
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SVC_A = 2'b01,
      SVC_B = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_b;
   logic             last_b_next;
   logic [1:0]       win_op;
   logic [WIDTH-1:0] win_mask;
   logic [WIDTH-1:0] j_next;
   logic [WIDTH-1:0] k_next;
   logic [WIDTH-1:0] q_next;

   // last_b = 1 means B won most recently; reset value lets A win the first tie
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         last_b <= 1'b1;
      end else begin
         state  <= state_next;
         last_b <= last_b_next;
      end
   end

   always_comb begin
      state_next  = IDLE;
      last_b_next = last_b;
      if (req_a && req_b) begin
         state_next = last_b ? SVC_A : SVC_B;
      end else if (req_a) begin
         state_next = SVC_A;
      end else if (req_b) begin
         state_next = SVC_B;
      end
      if (state_next == SVC_A) begin
         last_b_next = 1'b0;
      end else if (state_next == SVC_B) begin
         last_b_next = 1'b1;
      end
   end

   always_comb begin
      gnt_a = (state == SVC_A);
      gnt_b = (state == SVC_B);
   end

   // The winner's op/mask is applied at the same edge that enters the service state
   always_comb begin
      win_op   = '0;
      win_mask = '0;
      case (state_next)
         SVC_A: begin
            win_op   = op_a;
            win_mask = mask_a;
         end
         SVC_B: begin
            win_op   = op_b;
            win_mask = mask_b;
         end
         default: begin
            win_op   = '0;
            win_mask = '0;
         end
      endcase
      j_next = win_mask & {WIDTH{win_op[1]}};
      k_next = win_mask & {WIDTH{win_op[0]}};
      q_next = (j_next & ~q) | (~k_next & q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q     <= '0;
         j_vec <= '0;
         k_vec <= '0;
      end else begin
         q     <= q_next;
         j_vec <= j_next;
         k_vec <= k_next;
      end
   end

`ifdef JK_BANK_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_a <= '0;
         stat_b <= '0;
      end else begin
         if ((state_next == SVC_A) && (stat_a != 8'hFF)) begin
            stat_a <= stat_a + 8'd1;
         end
         if ((state_next == SVC_B) && (stat_b != 8'hFF)) begin
            stat_b <= stat_b + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: stimulus pushes reference-model results, a monitor pops and compares.
// Stats ports are checked only when JK_BANK_STATS_EN is defined.
module tb_jk_bank_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, req_b;
   logic [1:0] op_a, op_b;
   logic [3:0] mask_a, mask_b;
   logic       gnt_a, gnt_b;
   logic [3:0] j_vec, k_vec, q;
`ifdef JK_BANK_STATS_EN
   logic [7:0] stat_a, stat_b;
`endif

   always #5 clk = ~clk;

   jk_bank_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .op_a(op_a), .mask_a(mask_a),
      .req_b(req_b), .op_b(op_b), .mask_b(mask_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b),
      .j_vec(j_vec), .k_vec(k_vec), .q(q)
`ifdef JK_BANK_STATS_EN
      , .stat_a(stat_a), .stat_b(stat_b)
`endif
   );

   typedef struct {
      logic       ga;
      logic       gb;
      logic [3:0] j;
      logic [3:0] k;
      logic [3:0] q;
      int         sa;
      int         sb;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   logic [3:0] m_q;
   bit         m_last_a;
   bit         m_ga, m_gb;
   int         m_sa, m_sb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and push the expected post-edge outputs
   task automatic cyc(input bit r, input bit ra, input logic [1:0] oa, input logic [3:0] ma,
                      input bit rb, input logic [1:0] ob, input logic [3:0] mb);
      exp_t e;
      int   win;
      logic [1:0] op;
      logic [3:0] mk;
      @(negedge clk);
      rst = r; req_a = ra; op_a = oa; mask_a = ma; req_b = rb; op_b = ob; mask_b = mb;
      e.j = 4'h0; e.k = 4'h0;
      if (!r) begin
         m_q = 4'h0; m_last_a = 1'b0; m_sa = 0; m_sb = 0;
         win = 0;
      end else begin
         if (ra && rb) win = m_last_a ? 2 : 1;
         else if (ra) win = 1;
         else if (rb) win = 2;
         else win = 0;
         if (win != 0) begin
            op = (win == 1) ? oa : ob;
            mk = (win == 1) ? ma : mb;
            for (int i = 0; i < 4; i++) begin
               if (mk[i]) begin
                  case (op)
                     2'd1: m_q[i] = 1'b0;
                     2'd2: m_q[i] = 1'b1;
                     2'd3: m_q[i] = ~m_q[i];
                     default: ;
                  endcase
               end
            end
            e.j = (op == 2'd2 || op == 2'd3) ? mk : 4'h0;
            e.k = (op == 2'd1 || op == 2'd3) ? mk : 4'h0;
            m_last_a = (win == 1);
            if (win == 1 && m_sa < 255) m_sa++;
            if (win == 2 && m_sb < 255) m_sb++;
         end
      end
      m_ga = (win == 1);
      m_gb = (win == 2);
      e.ga = m_ga; e.gb = m_gb; e.q = m_q; e.sa = m_sa; e.sb = m_sb;
      sb_q.push_back(e);
   endtask

   // Monitor: every edge produces one registered response
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("gnt_a", 32'(gnt_a), 32'(e.ga));
            chk("gnt_b", 32'(gnt_b), 32'(e.gb));
            chk("j_vec", 32'(j_vec), 32'(e.j));
            chk("k_vec", 32'(k_vec), 32'(e.k));
            chk("q",     32'(q),     32'(e.q));
            chk("one_hot_gnt", 32'(gnt_a & gnt_b), 32'd0);
`ifdef JK_BANK_STATS_EN
            chk("stat_a", 32'(stat_a), 32'(e.sa));
            chk("stat_b", 32'(stat_b), 32'(e.sb));
`endif
         end
      end
   end

   initial begin
      bit         pa, pb;
      logic [1:0] poa, pob;
      logic [3:0] pma, pmb;
      int         wait_cnt;

      rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
      op_a = 2'd0; op_b = 2'd0; mask_a = 4'h0; mask_b = 4'h0;

      // Reset with a pending set request, then release
      cyc(0, 1, 2'd2, 4'hF, 0, 2'd0, 4'h0);
      cyc(0, 1, 2'd2, 4'hF, 0, 2'd0, 4'h0);
      cyc(1, 1, 2'd2, 4'hF, 0, 2'd0, 4'h0);

      // Operations on A
      cyc(0, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0);
      cyc(1, 1, 2'd2, 4'h5, 0, 2'd0, 4'h0);
      cyc(1, 1, 2'd3, 4'h3, 0, 2'd0, 4'h0);
      cyc(1, 1, 2'd1, 4'h4, 0, 2'd0, 4'h0);

      // Tie and round-robin
      cyc(0, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 2'd0, 4'hF, 1, 2'd0, 4'hF);
      cyc(0, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0);
      for (int i = 0; i < 6; i++) cyc(1, 1, 2'd2, 4'h1, 1, 2'd1, 4'h1);

      // Single requester back-to-back, then A arrives
      for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, 4'h0, 1, 2'd3, 4'h8);
      cyc(1, 1, 2'd2, 4'h2, 1, 2'd3, 4'h8);

      // Idle and hold
      cyc(0, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0);
      cyc(1, 1, 2'd2, 4'hA, 0, 2'd0, 4'h0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0);
      cyc(1, 1, 2'd0, 4'hF, 0, 2'd0, 4'h0);

      // 300 consecutive grants to A (saturates stat_a), then reset
      for (int i = 0; i < 300; i++)
         cyc(1, 1, 2'($urandom_range(0, 3)), 4'($urandom), 0, 2'd0, 4'h0);
      cyc(0, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0);

      // Random traffic obeying the hold-until-grant handshake
      pa = 0; pb = 0; poa = 0; pob = 0; pma = 0; pmb = 0;
      for (int i = 0; i < 500; i++) begin
         if (!pa || m_ga) begin
            pa  = ($urandom_range(0, 3) != 0);
            poa = 2'($urandom_range(0, 3));
            pma = 4'($urandom);
         end
         if (!pb || m_gb) begin
            pb  = ($urandom_range(0, 3) != 0);
            pob = 2'($urandom_range(0, 3));
            pmb = 4'($urandom);
         end
         cyc(($urandom_range(0, 59) != 0), pa, poa, pma, pb, pob, pmb);
      end
      cyc(1, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0);

      wait_cnt = 0;
      while (sb_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         #2;
         wait_cnt++;
      end
      chk("drain", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
